// File: rtl/hvardelay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hvardelay
//  Purpose  : Runtime-programmable, multi-lane delay line built on a circular
//             buffer. Delay depth is chosen per run (1..MAX_DELAY enabled
//             cycles), with stall, synchronous flush and output-valid
//             tracking. All lanes share one set of controls.
//  Ports    : hclk      - clock, rising edge
//             hres      - asynchronous active-high reset
//             hen       - advance enable (0 freezes the line)
//             hflush    - synchronous clear of history and valid state
//             hdly      - requested delay (clamped to 1..MAX_DELAY)
//             hin       - packed lane input, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//             hout      - registered delayed output, same packing as hin
//             hvout     - hout holds a genuinely delayed sample
//             hdly_act  - delay currently in effect (registered, clamped)
//  Revision : 1.0 - initial release
// ============================================================================
module hvardelay #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_CH     = 1,
    parameter int                    MAX_DELAY  = 16,
    parameter logic [DATA_WIDTH-1:0] HINIT      = '0,
    localparam int                   DW         = $clog2(MAX_DELAY + 1)
) (
    input  logic                         hclk,
    input  logic                         hres,
    input  logic                         hen,
    input  logic                         hflush,
    input  logic [DW-1:0]                hdly,
    input  logic [NUM_CH*DATA_WIDTH-1:0] hin,
    output logic [NUM_CH*DATA_WIDTH-1:0] hout,
    output logic                         hvout,
    output logic [DW-1:0]                hdly_act
);

    // Pointer width: enough to address MAX_DELAY entries.
    localparam int                c_pw    = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int                c_bw    = NUM_CH * DATA_WIDTH;
    localparam logic [DW-1:0]     c_max   = DW'(MAX_DELAY);
    localparam logic [DW-1:0]     c_one   = DW'(1);
    localparam logic [c_pw:0]     c_depth = (c_pw + 1)'(MAX_DELAY);
    localparam logic [c_pw-1:0]   c_last  = c_pw'(MAX_DELAY - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_bw-1:0] r_mem [MAX_DELAY];
    logic [c_pw-1:0] r_wp;
    logic [DW-1:0]   r_fill;
    logic [DW-1:0]   r_dly_act;
    logic [c_bw-1:0] r_out;
    logic            r_vout;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_bw-1:0] w_init;
    logic [DW-1:0]   w_dly_c;
    logic            w_change;
    logic            w_wr_en;
    logic [c_pw-1:0] w_wp_next;
    logic [DW-1:0]   w_back;
    logic [c_pw:0]   w_rd_sum;
    logic [c_pw-1:0] w_rd;
    logic [c_bw-1:0] w_rd_data;
    logic [DW:0]     w_fill_inc;
    logic [DW-1:0]   w_fill_next;
    logic            w_vout_next;

    // Reset/flush value: HINIT replicated into every lane.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane_init
        assign w_init[gi*DATA_WIDTH +: DATA_WIDTH] = HINIT;
    end

    always_comb begin
        // Clamp the request into the supported range 1..MAX_DELAY.
        w_dly_c = hdly;
        if (hdly == '0) begin
            w_dly_c = c_one;
        end else if (hdly > c_max) begin
            w_dly_c = c_max;
        end
    end

    assign w_change  = (w_dly_c != r_dly_act);

    // The incoming sample is stored whenever the line advances, including
    // the cycle of a delay change, so history is not lost across a change.
    assign w_wr_en   = hen & ~hflush;

    assign w_wp_next = (r_wp == c_last) ? '0 : r_wp + c_pw'(1);

    // Read address = (wp - (D-1)) mod MAX_DELAY. MAX_DELAY is added before
    // subtracting so the intermediate never goes negative; D-1 is at most
    // MAX_DELAY-1 so a single conditional subtract finishes the modulo.
    assign w_back    = r_dly_act - c_one;
    assign w_rd_sum  = {1'b0, r_wp} + c_depth - (c_pw + 1)'(w_back);
    assign w_rd      = (w_rd_sum >= c_depth) ? c_pw'(w_rd_sum - c_depth)
                                             : c_pw'(w_rd_sum);

    // D=1 bypasses the buffer: the output is the sample arriving this cycle.
    // For D>=2 the slot read was written D-1 enabled cycles ago and cannot
    // be the slot being overwritten now.
    assign w_rd_data = (r_dly_act == c_one) ? hin : r_mem[w_rd];

    // Fill saturates at MAX_DELAY; valid is judged on the incremented count.
    assign w_fill_inc  = {1'b0, r_fill} + {{DW{1'b0}}, 1'b1};
    assign w_fill_next = (r_fill == c_max) ? r_fill : w_fill_inc[DW-1:0];
    assign w_vout_next = (w_fill_inc >= {1'b0, r_dly_act});

    // ------------------------------------------------------------------
    // Sample storage (contents are don't-care after reset, so no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (w_wr_en) begin
            r_mem[r_wp] <= hin;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // Priority: reset, flush, delay change, enabled advance, stall.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hres) begin
        if (hres) begin
            r_out     <= w_init;
            r_vout    <= 1'b0;
            r_dly_act <= c_one;
            r_fill    <= '0;
            r_wp      <= '0;
        end else if (hflush) begin
            r_out     <= w_init;
            r_vout    <= 1'b0;
            r_dly_act <= w_dly_c;
            r_fill    <= '0;
            r_wp      <= '0;
        end else if (w_change) begin
            // New depth: restart the fill count and hold the output. The
            // sample is still accepted, but this cycle does not count
            // towards refilling at the new depth.
            r_dly_act <= w_dly_c;
            r_fill    <= '0;
            r_vout    <= 1'b0;
            if (hen) begin
                r_wp <= w_wp_next;
            end
        end else if (hen) begin
            r_out  <= w_rd_data;
            r_fill <= w_fill_next;
            r_vout <= w_vout_next;
            r_wp   <= w_wp_next;
        end
    end

    assign hout     = r_out;
    assign hvout    = r_vout;
    assign hdly_act = r_dly_act;

endmodule
`default_nettype wire

// File: tb/tb_hvardelay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hvardelay
//  Purpose  : Self-checking bench for hvardelay (3 lanes x 8 bits,
//             MAX_DELAY=16). Stimulus steps push expected responses into a
//             queue; a monitor pops and compares after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hvardelay;

    localparam int               DWID  = 8;
    localparam int               NCH   = 3;
    localparam int               MAXD  = 16;
    localparam int               DWD   = $clog2(MAXD + 1);
    localparam int               BW    = NCH * DWID;
    localparam logic [DWID-1:0]  HINIT = 8'h5A;

    logic           hclk;
    logic           hres;
    logic           hen;
    logic           hflush;
    logic [DWD-1:0] hdly;
    logic [BW-1:0]  hin;
    logic [BW-1:0]  hout;
    logic           hvout;
    logic [DWD-1:0] hdly_act;

    hvardelay #(
        .DATA_WIDTH (DWID),
        .NUM_CH     (NCH),
        .MAX_DELAY  (MAXD),
        .HINIT      (HINIT)
    ) u_dut (
        .hclk     (hclk),
        .hres     (hres),
        .hen      (hen),
        .hflush   (hflush),
        .hdly     (hdly),
        .hin      (hin),
        .hout     (hout),
        .hvout    (hvout),
        .hdly_act (hdly_act)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic          v;
        logic          known;
        logic [BW-1:0] out;
        int            dact;
    } exp_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model state: accepted-sample history, newest first.
    logic [BW-1:0] hist[$];
    int            m_dact;
    int            m_fill;
    logic          m_v;
    logic          m_known;
    logic [BW-1:0] m_out;
    logic [BW-1:0] init_v;

    function automatic logic [BW-1:0] lanes(input int n);
        logic [BW-1:0] r;
        r[7:0]   = 8'(n);
        r[15:8]  = 8'(8'h80 + n);
        r[23:16] = 8'(8'hF0 + n);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out   = init_v;
        m_known = 1'b1;
        m_v     = 1'b0;
        m_fill  = 0;
        m_dact  = 1;
        hist.delete();
    endtask

    task automatic push_hist(input logic [BW-1:0] d);
        hist.push_front(d);
        if (hist.size() > MAXD) void'(hist.pop_back());
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the
    // response expected after the following rising edge.
    task automatic step(input logic en, input logic fl, input int dly, input logic [BW-1:0] d);
        int   c;
        exp_t e;
        @(negedge hclk);
        hen    = en;
        hflush = fl;
        hdly   = DWD'(dly);
        hin    = d;
        c = (dly == 0) ? 1 : ((dly > MAXD) ? MAXD : dly);
        if (fl) begin
            m_out   = init_v;
            m_known = 1'b1;
            m_v     = 1'b0;
            m_fill  = 0;
            m_dact  = c;
            hist.delete();
        end else if (c != m_dact) begin
            m_dact = c;
            m_fill = 0;
            m_v    = 1'b0;
            if (en) push_hist(d);
        end else if (en) begin
            if (m_dact == 1) begin
                m_out   = d;
                m_known = 1'b1;
            end else if (hist.size() >= m_dact - 1) begin
                m_out   = hist[m_dact-2];
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
            m_v    = (m_fill + 1 >= m_dact);
            m_fill = (m_fill + 1 > MAXD) ? MAXD : m_fill + 1;
            push_hist(d);
        end
        e.v     = m_v;
        e.known = m_known;
        e.out   = m_out;
        e.dact  = m_dact;
        q.push_back(e);
    endtask

    // Asynchronous reset asserted between edges; outputs must respond
    // without waiting for a clock.
    task automatic async_reset();
        @(negedge hclk);
        hen    = 1'b0;
        hflush = 1'b0;
        hdly   = DWD'(1);
        #2;
        hres = 1'b1;
        #1;
        chk("async_rst_hout", hout, init_v);
        chk("async_rst_hvout", hvout, 1'b0);
        chk("async_rst_dact", hdly_act, 1);
        model_reset();
        @(negedge hclk);
        hres = 1'b0;
    endtask

    // Monitor: compares every queued expectation one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_hvout", hvout, e.v);
                chk("sb_hdly_act", hdly_act, e.dact);
                if (e.known) chk("sb_hout", hout, e.out);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_v = {NCH{HINIT}};
        hres   = 1'b1;
        hen    = 1'b0;
        hflush = 1'b0;
        hdly   = DWD'(1);
        hin    = '0;
        model_reset();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hres = 1'b0;
        #1;
        chk("reset_hout", hout, init_v);
        chk("reset_hvout", hvout, 1'b0);
        chk("reset_dact", hdly_act, 1);

        // Fixed delay of 5 from a clean flush; valid rises on the 5th edge.
        step(1'b0, 1'b1, 5, lanes(0));
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 5, lanes(k + 1));
            @(posedge hclk);
            #2;
            if (k == 3) chk("t1_not_yet_valid", hvout, 1'b0);
            if (k == 4) begin
                chk("t1_valid_rise", hvout, 1'b1);
                chk("t1_first_out", hout[7:0], 8'd1);
            end
            if (k == 5) chk("t1_second_out", hout[7:0], 8'd2);
            if (k == 11) chk("t1_steady_lag", hout[7:0], 8'd8);
        end

        // Stall mid-stream at delay 3; junk input during the stall.
        for (int k = 0; k < 8; k++)  step(1'b1, 1'b0, 3, lanes(10 + k));
        for (int k = 0; k < 4; k++)  step(1'b0, 1'b0, 3, lanes(8'hEE));
        for (int k = 8; k < 16; k++) step(1'b1, 1'b0, 3, lanes(10 + k));

        // Delay changes 4 -> 7 -> 2 while streaming.
        for (int k = 0; k < 8; k++)  step(1'b1, 1'b0, 4, lanes(30 + k));
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 7, lanes(40 + k));
        for (int k = 0; k < 6; k++)  step(1'b1, 1'b0, 2, lanes(60 + k));

        // Clamp: 0 behaves as 1, 20 as 16; long run covers pointer wrap.
        for (int k = 0; k < 5; k++)  step(1'b1, 1'b0, 0, lanes(70 + k));
        for (int k = 0; k < 45; k++) step(1'b1, 1'b0, 20, lanes(100 + k));

        // Flush with hen low, then refill; then async reset mid-stream.
        for (int k = 0; k < 6; k++)  step(1'b1, 1'b0, 3, lanes(150 + k));
        step(1'b0, 1'b1, 3, lanes(8'hCC));
        for (int k = 0; k < 6; k++)  step(1'b1, 1'b0, 3, lanes(160 + k));
        async_reset();

        // Multi-lane alignment at delay 2.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 2, lanes(200 + k));

        @(posedge hclk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
